// File: rtl/rs_alu_sched.sv
`default_nettype none
// ============================================================================
// Module      : rs_alu_sched
// Description : ALU reservation station; wakes operands from two CDBs and
//               dispatches the lowest-index ready entry to the ALU each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_alu_sched #(
    parameter int RS_SIZE = 8,
    parameter int ROB_W   = 4
) (
    input  logic                           clk_in,
    input  logic                           rst_n,
    input  logic                           clear_in,
    input  logic                           issue_valid,
    input  logic [5:0]                     issue_op,
    input  logic [ROB_W-1:0]               issue_rob,
    input  logic                           issue_q1_busy,
    input  logic                           issue_q2_busy,
    input  logic [ROB_W-1:0]               issue_q1,
    input  logic [ROB_W-1:0]               issue_q2,
    input  logic [31:0]                    issue_v1,
    input  logic [31:0]                    issue_v2,
    output logic                           full_out,
    output logic [$clog2(RS_SIZE+1)-1:0]   count_out,
    input  logic                           cdb0_valid,
    input  logic [ROB_W-1:0]               cdb0_rob,
    input  logic [31:0]                    cdb0_val,
    input  logic                           cdb1_valid,
    input  logic [ROB_W-1:0]               cdb1_rob,
    input  logic [31:0]                    cdb1_val,
    output logic                           alu_flag,
    output logic [5:0]                     alu_op,
    output logic [31:0]                    alu_val1,
    output logic [31:0]                    alu_val2,
    output logic [ROB_W-1:0]               alu_rob
);

    localparam int c_cnt_w = $clog2(RS_SIZE+1);
    localparam int c_idx_w = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0] r_valid;
    logic [RS_SIZE-1:0] r_q1_busy;
    logic [RS_SIZE-1:0] r_q2_busy;
    logic [5:0]         r_op  [RS_SIZE];
    logic [ROB_W-1:0]   r_rob [RS_SIZE];
    logic [ROB_W-1:0]   r_q1  [RS_SIZE];
    logic [ROB_W-1:0]   r_q2  [RS_SIZE];
    logic [31:0]        r_v1  [RS_SIZE];
    logic [31:0]        r_v2  [RS_SIZE];

    logic [c_cnt_w-1:0] r_count;
    logic               r_alu_flag;
    logic [5:0]         r_alu_op;
    logic [31:0]        r_alu_val1;
    logic [31:0]        r_alu_val2;
    logic [ROB_W-1:0]   r_alu_rob;

    logic [RS_SIZE-1:0] w_ready;
    logic               w_full;
    logic               w_issue_acc;
    logic               w_free_found;
    logic [c_idx_w-1:0] w_free_idx;
    logic               w_sel_found;
    logic [c_idx_w-1:0] w_sel_idx;
    logic               w_iss_q1_busy;
    logic               w_iss_q2_busy;
    logic [31:0]        w_iss_v1;
    logic [31:0]        w_iss_v2;

    assign w_ready     = r_valid & ~r_q1_busy & ~r_q2_busy;
    assign w_full      = (r_count == c_cnt_w'(RS_SIZE));
    assign w_issue_acc = issue_valid & ~w_full & ~clear_in;

    // Descending scan so the lowest index wins for both searches.
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_sel_found  = 1'b0;
        w_sel_idx    = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = c_idx_w'(i);
            end
            if (w_ready[i]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = c_idx_w'(i);
            end
        end
    end

    // Operands produced in the issue cycle are captured directly from the CDB.
    always_comb begin
        w_iss_q1_busy = issue_q1_busy;
        w_iss_v1      = issue_v1;
        w_iss_q2_busy = issue_q2_busy;
        w_iss_v2      = issue_v2;
        if (issue_q1_busy) begin
            if (cdb0_valid && cdb0_rob == issue_q1) begin
                w_iss_q1_busy = 1'b0;
                w_iss_v1      = cdb0_val;
            end else if (cdb1_valid && cdb1_rob == issue_q1) begin
                w_iss_q1_busy = 1'b0;
                w_iss_v1      = cdb1_val;
            end
        end
        if (issue_q2_busy) begin
            if (cdb0_valid && cdb0_rob == issue_q2) begin
                w_iss_q2_busy = 1'b0;
                w_iss_v2      = cdb0_val;
            end else if (cdb1_valid && cdb1_rob == issue_q2) begin
                w_iss_q2_busy = 1'b0;
                w_iss_v2      = cdb1_val;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            r_valid    <= '0;
            r_count    <= '0;
            r_alu_flag <= 1'b0;
            r_alu_op   <= '0;
            r_alu_val1 <= '0;
            r_alu_val2 <= '0;
            r_alu_rob  <= '0;
        end else if (clear_in) begin
            r_valid    <= '0;
            r_count    <= '0;
            r_alu_flag <= 1'b0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (r_valid[i] && r_q1_busy[i]) begin
                    if (cdb0_valid && cdb0_rob == r_q1[i]) begin
                        r_q1_busy[i] <= 1'b0;
                        r_v1[i]      <= cdb0_val;
                    end else if (cdb1_valid && cdb1_rob == r_q1[i]) begin
                        r_q1_busy[i] <= 1'b0;
                        r_v1[i]      <= cdb1_val;
                    end
                end
                if (r_valid[i] && r_q2_busy[i]) begin
                    if (cdb0_valid && cdb0_rob == r_q2[i]) begin
                        r_q2_busy[i] <= 1'b0;
                        r_v2[i]      <= cdb0_val;
                    end else if (cdb1_valid && cdb1_rob == r_q2[i]) begin
                        r_q2_busy[i] <= 1'b0;
                        r_v2[i]      <= cdb1_val;
                    end
                end
            end

            if (w_sel_found) begin
                r_valid[w_sel_idx] <= 1'b0;
                r_alu_flag         <= 1'b1;
                r_alu_op           <= r_op[w_sel_idx];
                r_alu_val1         <= r_v1[w_sel_idx];
                r_alu_val2         <= r_v2[w_sel_idx];
                r_alu_rob          <= r_rob[w_sel_idx];
            end else begin
                r_alu_flag <= 1'b0;
            end

            // The free slot is invalid pre-edge, so it never collides with wakeup or select.
            if (w_issue_acc && w_free_found) begin
                r_valid[w_free_idx]   <= 1'b1;
                r_op[w_free_idx]      <= issue_op;
                r_rob[w_free_idx]     <= issue_rob;
                r_q1_busy[w_free_idx] <= w_iss_q1_busy;
                r_q1[w_free_idx]      <= issue_q1;
                r_v1[w_free_idx]      <= w_iss_v1;
                r_q2_busy[w_free_idx] <= w_iss_q2_busy;
                r_q2[w_free_idx]      <= issue_q2;
                r_v2[w_free_idx]      <= w_iss_v2;
            end

            r_count <= r_count + c_cnt_w'(w_issue_acc && w_free_found) - c_cnt_w'(w_sel_found);
        end
    end

    assign full_out  = w_full;
    assign count_out = r_count;
    assign alu_flag  = r_alu_flag;
    assign alu_op    = r_alu_op;
    assign alu_val1  = r_alu_val1;
    assign alu_val2  = r_alu_val2;
    assign alu_rob   = r_alu_rob;

endmodule
`default_nettype wire

// File: tb/tb_rs_alu_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_rs_alu_sched
// Description : Directed scoreboard bench for rs_alu_sched.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rs_alu_sched;

    localparam int RS_SIZE = 8;
    localparam int ROB_W   = 4;
    localparam logic [5:0] c_op_add = 6'd1;
    localparam logic [5:0] c_op_sub = 6'd2;

    logic              clk_in = 1'b0;
    logic              rst_n;
    logic              clear_in;
    logic              issue_valid;
    logic [5:0]        issue_op;
    logic [ROB_W-1:0]  issue_rob;
    logic              issue_q1_busy, issue_q2_busy;
    logic [ROB_W-1:0]  issue_q1, issue_q2;
    logic [31:0]       issue_v1, issue_v2;
    logic              full_out;
    logic [3:0]        count_out;
    logic              cdb0_valid, cdb1_valid;
    logic [ROB_W-1:0]  cdb0_rob, cdb1_rob;
    logic [31:0]       cdb0_val, cdb1_val;
    logic              alu_flag;
    logic [5:0]        alu_op;
    logic [31:0]       alu_val1, alu_val2;
    logic [ROB_W-1:0]  alu_rob;

    int errors = 0;
    int checks = 0;
    logic [73:0] sb[$];

    rs_alu_sched #(.RS_SIZE(RS_SIZE), .ROB_W(ROB_W)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .clear_in(clear_in),
        .issue_valid(issue_valid), .issue_op(issue_op), .issue_rob(issue_rob),
        .issue_q1_busy(issue_q1_busy), .issue_q2_busy(issue_q2_busy),
        .issue_q1(issue_q1), .issue_q2(issue_q2),
        .issue_v1(issue_v1), .issue_v2(issue_v2),
        .full_out(full_out), .count_out(count_out),
        .cdb0_valid(cdb0_valid), .cdb0_rob(cdb0_rob), .cdb0_val(cdb0_val),
        .cdb1_valid(cdb1_valid), .cdb1_rob(cdb1_rob), .cdb1_val(cdb1_val),
        .alu_flag(alu_flag), .alu_op(alu_op), .alu_val1(alu_val1),
        .alu_val2(alu_val2), .alu_rob(alu_rob)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [73:0] obs, input logic [73:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [5:0] op, input logic [31:0] v1,
                            input logic [31:0] v2, input logic [ROB_W-1:0] rob);
        sb.push_back({op, v1, v2, rob});
    endtask

    // One clock edge; checks alu_flag and, on a dispatch, the scoreboard head.
    task automatic tick(input logic exp_flag, input string tag);
        logic [73:0] e;
        @(posedge clk_in);
        #1;
        chk({tag, ".flag"}, {73'd0, alu_flag}, {73'd0, exp_flag});
        if (alu_flag === 1'b1) begin
            chk({tag, ".sb_pending"}, {73'd0, sb.size() != 0}, 74'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk({tag, ".payload"}, {alu_op, alu_val1, alu_val2, alu_rob}, e);
            end
        end
    endtask

    task automatic chk_occ(input string tag, input int cnt, input logic full);
        chk({tag, ".count"}, {70'd0, count_out}, 74'(cnt));
        chk({tag, ".full"}, {73'd0, full_out}, {73'd0, full});
    endtask

    task automatic idle_inputs();
        clear_in      = 1'b0;
        issue_valid   = 1'b0;
        issue_op      = '0;
        issue_rob     = '0;
        issue_q1_busy = 1'b0;
        issue_q2_busy = 1'b0;
        issue_q1      = '0;
        issue_q2      = '0;
        issue_v1      = '0;
        issue_v2      = '0;
        cdb0_valid    = 1'b0;
        cdb0_rob      = '0;
        cdb0_val      = '0;
        cdb1_valid    = 1'b0;
        cdb1_rob      = '0;
        cdb1_val      = '0;
    endtask

    task automatic drive_issue(input logic [5:0] op, input logic [ROB_W-1:0] rob,
                               input logic q1b, input logic [ROB_W-1:0] q1, input logic [31:0] v1,
                               input logic q2b, input logic [ROB_W-1:0] q2, input logic [31:0] v2);
        issue_valid   = 1'b1;
        issue_op      = op;
        issue_rob     = rob;
        issue_q1_busy = q1b;
        issue_q1      = q1;
        issue_v1      = v1;
        issue_q2_busy = q2b;
        issue_q2      = q2;
        issue_v2      = v2;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk_in);
        @(posedge clk_in);
        #1;
        rst_n = 1'b1;

        // Reset then idle
        chk("rst.outs", {alu_op, alu_val1, alu_val2, alu_rob}, 74'd0);
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, "idle");
            chk_occ("idle", 0, 1'b0);
        end

        // Ready ADD: write edge, then dispatch edge
        drive_issue(c_op_add, 4'd3, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd7);
        tick(1'b0, "add.write");
        chk_occ("add.write", 1, 1'b0);
        idle_inputs();
        push_exp(c_op_add, 32'd5, 32'd7, 4'd3);
        tick(1'b1, "add.disp");
        chk_occ("add.disp", 0, 1'b0);
        tick(1'b0, "add.after");
        chk("add.hold_val1", {42'd0, alu_val1}, 74'd5);

        // Dependent SUB woken by cdb0 two cycles after issue
        drive_issue(c_op_sub, 4'd4, 1'b1, 4'd3, 32'd0, 1'b0, 4'd0, 32'd2);
        tick(1'b0, "sub.write");
        idle_inputs();
        tick(1'b0, "sub.wait");
        cdb0_valid = 1'b1; cdb0_rob = 4'd3; cdb0_val = 32'd12;
        tick(1'b0, "sub.wake");
        idle_inputs();
        push_exp(c_op_sub, 32'd12, 32'd2, 4'd4);
        tick(1'b1, "sub.disp");
        tick(1'b0, "sub.after");

        // Issue-time bypass from cdb0
        drive_issue(c_op_sub, 4'd5, 1'b1, 4'd3, 32'd0, 1'b0, 4'd0, 32'd2);
        cdb0_valid = 1'b1; cdb0_rob = 4'd3; cdb0_val = 32'd20;
        tick(1'b0, "byp.write");
        idle_inputs();
        push_exp(c_op_sub, 32'd20, 32'd2, 4'd5);
        tick(1'b1, "byp.disp");
        tick(1'b0, "byp.after");
        chk_occ("byp.after", 0, 1'b0);

        // Fill 8 non-ready entries; entry i waits on tag 8+i, entry 6 shares tag 11 with entry 3
        for (int i = 0; i < RS_SIZE; i++) begin
            drive_issue(c_op_add, ROB_W'(i), 1'b1, (i == 6) ? 4'd11 : ROB_W'(8 + i), 32'd0,
                        1'b0, 4'd0, 32'(i));
            tick(1'b0, "fill");
        end
        chk_occ("fill.full", 8, 1'b1);

        // 9th issue held by upstream: dropped while full; cdb1 wakes entry 2 the same cycle
        drive_issue(c_op_add, 4'd14, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd1);
        cdb1_valid = 1'b1; cdb1_rob = 4'd10; cdb1_val = 32'd100;
        tick(1'b0, "ninth.drop");
        chk_occ("ninth.drop", 8, 1'b1);
        cdb1_valid = 1'b0;
        push_exp(c_op_add, 32'd100, 32'd2, 4'd2);
        tick(1'b1, "ninth.disp");
        chk_occ("ninth.disp", 7, 1'b0);
        tick(1'b0, "ninth.accept");
        chk_occ("ninth.accept", 8, 1'b1);
        idle_inputs();
        push_exp(c_op_add, 32'd1, 32'd1, 4'd14);
        tick(1'b1, "ninth.run");
        chk_occ("ninth.run", 7, 1'b0);

        // One broadcast wakes entries 3 and 6; lower index first
        cdb0_valid = 1'b1; cdb0_rob = 4'd11; cdb0_val = 32'd55;
        tick(1'b0, "pair.wake");
        idle_inputs();
        push_exp(c_op_add, 32'd55, 32'd3, 4'd3);
        push_exp(c_op_add, 32'd55, 32'd6, 4'd6);
        tick(1'b1, "pair.first");
        tick(1'b1, "pair.second");
        tick(1'b0, "pair.after");
        chk_occ("pair.after", 5, 1'b0);

        // Clear with 5 entries, one ready, plus a CDB match and an issue in the clear cycle
        cdb1_valid = 1'b1; cdb1_rob = 4'd8; cdb1_val = 32'd9;
        tick(1'b0, "clr.wake");
        idle_inputs();
        clear_in = 1'b1;
        cdb0_valid = 1'b1; cdb0_rob = 4'd12; cdb0_val = 32'd77;
        drive_issue(c_op_add, 4'd15, 1'b0, 4'd0, 32'd3, 1'b0, 4'd0, 32'd4);
        tick(1'b0, "clr.edge");
        chk_occ("clr.edge", 0, 1'b0);
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, "clr.idle");
            chk_occ("clr.idle", 0, 1'b0);
        end

        chk("sb.drained", 74'(sb.size()), 74'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
